// File: rtl/row_policy.sv
// Per-bank open-row tracker: classifies requests as HIT/MISS/CONFLICT and issues idle-timeout precharges.
// Latency: row_stat is registered, 1 cycle after acceptance; close offers appear 1 cycle after expiry.
// Backpressure: req_ready drops during refresh or when the target bank is being offered for precharge.
module row_policy #(
    parameter int BG_W    = 2,
    parameter int BA_W    = 2,
    parameter int ROW_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                                  CLK,
    input  logic                                  nRST,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [BG_W-1:0]                       bank_group,
    input  logic [BA_W-1:0]                       bank,
    input  logic [ROW_W-1:0]                      row,
    input  logic                                  row_resolve,
    input  logic                                  refresh,
    output logic                                  stat_valid,
    output logic [1:0]                            row_stat,
    output logic [ROW_W-1:0]                      row_conflict,
    output logic                                  close_valid,
    output logic [BG_W+BA_W-1:0]                  close_bank,
    input  logic                                  close_ready,
    output logic [$clog2(2**(BG_W+BA_W)+1)-1:0]   open_count
);
    localparam int IDX_W = BG_W + BA_W;
    localparam int NB    = 2**IDX_W;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int OC_W  = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [NB-1:0]    valid_q, valid_nxt, cand;
    logic [CNT_W-1:0] cnt_q   [NB];
    logic [CNT_W-1:0] cnt_nxt [NB];
    logic [ROW_W-1:0] tag_q   [NB];
    logic [IDX_W-1:0] idx, cand_idx;
    logic [OC_W-1:0]  oc_nxt;
    logic             acc, row_open, tag_eq, close_fire;

    always_comb begin
        idx        = {bank_group, bank};
        req_ready  = !refresh && !(close_valid && idx == close_bank);
        acc        = req_valid && req_ready;
        row_open   = valid_q[idx];
        tag_eq     = tag_q[idx] == row;
        close_fire = close_valid && close_ready;
    end

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            valid_nxt[i] = valid_q[i];
            cnt_nxt[i]   = (cnt_q[i] != CNT_MAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
            if (close_fire && close_bank == IDX_W'(i))
                valid_nxt[i] = 1'b0;
            if (acc && idx == IDX_W'(i)) begin
                cnt_nxt[i]   = '0;
                // MISS opens, HIT keeps unless auto-precharged, CONFLICT closes
                valid_nxt[i] = !row_open || (tag_eq && !row_resolve);
            end
            if (refresh)
                valid_nxt[i] = 1'b0;
            if (!valid_nxt[i] || TIMEOUT == 0)
                cnt_nxt[i] = '0;
        end
    end

    // Candidates exclude banks being closed or touched this cycle, since their state is about to reset.
    always_comb begin
        cand     = '0;
        cand_idx = '0;
        oc_nxt   = '0;
        for (int i = 0; i < NB; i++) begin
            cand[i] = (TIMEOUT > 0) && valid_q[i] && (cnt_q[i] == CNT_MAX)
                      && !(close_fire && close_bank == IDX_W'(i))
                      && !(acc && idx == IDX_W'(i));
            oc_nxt  = oc_nxt + OC_W'(valid_nxt[i]);
        end
        for (int i = NB - 1; i >= 0; i--)
            if (cand[i])
                cand_idx = IDX_W'(i);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q      <= '0;
            open_count   <= '0;
            stat_valid   <= 1'b0;
            row_stat     <= 2'b00;
            row_conflict <= '0;
            close_valid  <= 1'b0;
            close_bank   <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_nxt;
            open_count <= oc_nxt;
            for (int i = 0; i < NB; i++)
                cnt_q[i] <= cnt_nxt[i];
            if (acc && !row_open)
                tag_q[idx] <= row;

            stat_valid   <= acc;
            row_stat     <= !acc ? 2'b00 : (!row_open ? 2'b10 : (tag_eq ? 2'b01 : 2'b11));
            row_conflict <= (acc && row_open && !tag_eq) ? tag_q[idx] : '0;

            if (refresh) begin
                close_valid <= 1'b0;
                close_bank  <= '0;
            end else if (!(close_valid && !close_ready)) begin
                close_valid <= |cand;
                close_bank  <= cand_idx;
            end
        end
    end
endmodule

// File: tb/tb_row_policy.sv
// Directed bench for row_policy: one open-row-only instance and one with a 4-cycle idle timeout,
// both driven from the same stimulus.
module tb_row_policy;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_valid, row_resolve, refresh, close_ready;
    logic [1:0]  bank_group, bank;
    logic [15:0] row;

    logic        rr0, sv0, cv0, rr4, sv4, cv4;
    logic [1:0]  rs0, rs4;
    logic [15:0] rc0, rc4;
    logic [3:0]  cb0, cb4;
    logic [4:0]  oc0, oc4;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    row_policy #(.TIMEOUT(0)) dut0 (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(rr0),
        .bank_group(bank_group), .bank(bank), .row(row), .row_resolve(row_resolve),
        .refresh(refresh), .stat_valid(sv0), .row_stat(rs0), .row_conflict(rc0),
        .close_valid(cv0), .close_bank(cb0), .close_ready(close_ready), .open_count(oc0)
    );

    row_policy #(.TIMEOUT(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(rr4),
        .bank_group(bank_group), .bank(bank), .row(row), .row_resolve(row_resolve),
        .refresh(refresh), .stat_valid(sv4), .row_stat(rs4), .row_conflict(rc4),
        .close_valid(cv4), .close_bank(cb4), .close_ready(close_ready), .open_count(oc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic setidx(input logic [3:0] i);
        bank_group = i[3:2];
        bank       = i[1:0];
    endtask

    task automatic req(input logic [3:0] i, input logic [15:0] r, input logic res);
        setidx(i);
        row         = r;
        row_resolve = res;
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
        row_resolve = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0; req_valid = 1'b0; row_resolve = 1'b0; refresh = 1'b0;
        close_ready = 1'b0; bank_group = '0; bank = '0; row = '0;
        #20;
        chk("rst_stat_valid", 32'(sv0), 0);
        chk("rst_row_stat", 32'(rs0), 0);
        chk("rst_open_count", 32'(oc4), 0);
        chk("rst_close_valid", 32'(cv4), 0);
        #3 nRST = 1'b1;
        tick();

        // open-row policy: MISS, HIT, CONFLICT on bank 0
        req(4'd0, 16'h0012, 1'b0);
        chk("miss_stat", 32'(rs0), 2);
        chk("miss_valid", 32'(sv0), 1);
        chk("miss_count", 32'(oc0), 1);
        req(4'd0, 16'h0012, 1'b0);
        chk("hit_stat", 32'(rs0), 1);
        chk("hit_conflict_row", 32'(rc0), 0);
        req(4'd0, 16'h0034, 1'b0);
        chk("conf_stat", 32'(rs0), 3);
        chk("conf_row", 32'(rc0), 16'h0012);
        chk("conf_count", 32'(oc0), 0);
        tick();
        chk("idle_stat_valid", 32'(sv0), 0);
        chk("idle_row_stat", 32'(rs0), 0);
        chk("idle_conflict", 32'(rc0), 0);

        // auto-precharge HIT on index 5
        req(4'd5, 16'h00ab, 1'b0);
        chk("r5_miss_count", 32'(oc0), 1);
        req(4'd5, 16'h00ab, 1'b1);
        chk("r5_hit_stat", 32'(rs0), 1);
        chk("r5_hit_count", 32'(oc0), 0);
        req(4'd5, 16'h00ab, 1'b0);
        chk("r5_remiss_stat", 32'(rs0), 2);
        for (int k = 0; k < 8; k++) tick();
        chk("t0_no_close", 32'(cv0), 0);
        chk("t0_count_held", 32'(oc0), 1);

        #2 nRST = 1'b0;
        #1 chk("rst2_count", 32'(oc0), 0);
        #2 nRST = 1'b1;
        tick();

        // timeout on index 3 with a stalled handshake
        req(4'd3, 16'h0077, 1'b0);
        chk("t4_miss", 32'(rs4), 2);
        for (int k = 0; k < 4; k++) tick();
        chk("t4_not_yet", 32'(cv4), 0);
        tick();
        chk("t4_close_valid", 32'(cv4), 1);
        chk("t4_close_bank", 32'(cb4), 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_hold_valid", 32'(cv4), 1);
            chk("t4_hold_bank", 32'(cb4), 3);
        end
        close_ready = 1'b1;
        tick();
        close_ready = 1'b0;
        chk("t4_done_valid", 32'(cv4), 0);
        chk("t4_done_count", 32'(oc4), 0);
        tick();
        chk("t4_stays_closed", 32'(cv4), 0);

        // lowest-index ordering among 0, 2, 9
        req(4'd0, 16'h0001, 1'b0);
        req(4'd9, 16'h0002, 1'b0);
        req(4'd2, 16'h0003, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        chk("ord_first_valid", 32'(cv4), 1);
        chk("ord_first_bank", 32'(cb4), 0);
        tick(); tick();
        chk("ord_held_bank", 32'(cb4), 0);
        setidx(4'd0);
        #1 chk("ord_rdy_offered", 32'(rr4), 0);
        setidx(4'd2);
        #1 chk("ord_rdy_other", 32'(rr4), 1);
        close_ready = 1'b1;
        tick();
        chk("ord_second_bank", 32'(cb4), 2);
        chk("ord_second_count", 32'(oc4), 2);
        setidx(4'd2);
        #1 chk("ord_rdy_idx2", 32'(rr4), 0);
        setidx(4'd9);
        #1 chk("ord_rdy_idx9", 32'(rr4), 1);
        tick();
        chk("ord_third_bank", 32'(cb4), 9);
        tick();
        close_ready = 1'b0;
        chk("ord_done_valid", 32'(cv4), 0);
        chk("ord_done_count", 32'(oc4), 0);

        // refresh with a concurrent request
        req(4'd1, 16'h0100, 1'b0);
        req(4'd4, 16'h0101, 1'b0);
        req(4'd7, 16'h0102, 1'b0);
        req(4'd12, 16'h0103, 1'b0);
        chk("ref_pre_count", 32'(oc4), 4);
        refresh = 1'b1;
        setidx(4'd1);
        row = 16'h0100;
        req_valid = 1'b1;
        #1 chk("ref_rdy4", 32'(rr4), 0);
        chk("ref_rdy0", 32'(rr0), 0);
        tick();
        refresh = 1'b0;
        req_valid = 1'b0;
        chk("ref_count4", 32'(oc4), 0);
        chk("ref_count0", 32'(oc0), 0);
        chk("ref_close", 32'(cv4), 0);
        chk("ref_stat_valid", 32'(sv4), 0);
        tick();
        chk("ref_close_later", 32'(cv4), 0);
        req(4'd1, 16'h0100, 1'b0);
        chk("ref_miss1", 32'(rs4), 2);
        req(4'd12, 16'h0103, 1'b0);
        chk("ref_miss12", 32'(rs4), 2);
        chk("ref_miss12_t0", 32'(rs0), 2);

        // reset in the middle of a close handshake
        tick(); tick(); tick();
        req(4'd6, 16'h0055, 1'b0);
        chk("mid_close_valid", 32'(cv4), 1);
        chk("mid_close_bank", 32'(cb4), 1);
        chk("mid_count", 32'(oc4), 3);
        close_ready = 1'b1;
        #2 nRST = 1'b0;
        #1;
        chk("arst_stat_valid", 32'(sv4), 0);
        chk("arst_row_stat", 32'(rs4), 0);
        chk("arst_conflict", 32'(rc4), 0);
        chk("arst_close_valid", 32'(cv4), 0);
        chk("arst_close_bank", 32'(cb4), 0);
        chk("arst_count", 32'(oc4), 0);
        #2 nRST = 1'b1;
        close_ready = 1'b0;
        tick();
        req(4'd1, 16'h0100, 1'b0);
        chk("post_rst_miss1", 32'(rs4), 2);
        req(4'd6, 16'h0055, 1'b0);
        chk("post_rst_miss6", 32'(rs4), 2);
        chk("post_rst_miss6_t0", 32'(rs0), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/row_policy.md
ROW_POLICY -- requirements
Module: row_policy

Interface
REQ-001 Parameter BG_W, default 2, bank-group address width.
REQ-002 Parameter BA_W, default 2, bank address width; NB = 2**(BG_W+BA_W) tracked banks.
REQ-003 Parameter ROW_W, default 16, row address width.
REQ-004 Parameter TIMEOUT, default 64, idle cycles before an open row is auto-closed; 0 disables auto-close (pure open-row policy).
REQ-005 CLK  input  1  single clock, all state on rising edge.
REQ-006 nRST  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  lookup request present.
REQ-008 req_ready  output  1  request accepted this cycle (combinational).
REQ-009 bank_group  input  BG_W  target bank group; index = {bank_group, bank}.
REQ-010 bank  input  BA_W  target bank.
REQ-011 row  input  ROW_W  target row.
REQ-012 row_resolve  input  1  on a HIT, close the row after this access (auto-precharge).
REQ-013 refresh  input  1  all-bank refresh; closes every row.
REQ-014 stat_valid  output  1  row_stat/row_conflict valid (registered).
REQ-015 row_stat  output  2  00 none, 01 HIT, 10 MISS, 11 CONFLICT.
REQ-016 row_conflict  output  ROW_W  row open at the time of a CONFLICT, else 0.
REQ-017 close_valid  output  1  timeout precharge request pending.
REQ-018 close_bank  output  BG_W+BA_W  bank index to precharge.
REQ-019 close_ready  input  1  controller accepts the precharge request.
REQ-020 open_count  output  clog2(NB+1)  number of banks with a valid open row (registered).

Function
REQ-021 Per bank: valid bit, ROW_W row tag, idle counter saturating at TIMEOUT.
REQ-022 req_ready = !refresh && !(close_valid && index == close_bank).
REQ-023 Accepted request (req_valid && req_ready) yields stat_valid=1 with row_stat/row_conflict on the next cycle (latency 1); otherwise stat_valid=0, row_stat=00, row_conflict=0 next cycle.
REQ-024 HIT (valid, tag==row): row_stat=01; entry stays valid unless row_resolve=1, then valid cleared.
REQ-025 CONFLICT (valid, tag!=row): row_stat=11, row_conflict=old tag, valid cleared (tag not replaced).
REQ-026 MISS (invalid): row_stat=10, valid set, tag=row.
REQ-027 Any accepted request clears that bank's idle counter; every other valid bank's counter increments by 1 per cycle, saturating; invalid banks hold counter 0.
REQ-028 TIMEOUT>0: a bank is expired when valid and counter==TIMEOUT; close_valid asserts the cycle after any bank expires, close_bank = lowest expired index.
REQ-029 close_valid and close_bank hold stable until close_valid && close_ready; on that edge the bank's valid and counter clear and the next lowest expired bank (if any) is offered the following cycle.
REQ-030 TIMEOUT=0: close_valid is constantly 0, counters unused.
REQ-031 refresh=1: next cycle all valid bits and counters clear, close_valid=0, stat_valid=0; refresh overrides a simultaneous close handshake and request (request not accepted).
REQ-032 open_count equals popcount of valid bits, updated together with them.

Reset
REQ-033 nRST low asynchronously clears all valid bits, tags, counters; stat_valid=0, row_stat=00, row_conflict=0, close_valid=0, close_bank=0, open_count=0, regardless of activity in progress.
REQ-034 First request after reset release to any bank returns MISS.

Verification
REQ-035 Defaults, TIMEOUT=0: req bank 0/0 row 0x12 -> MISS; again row 0x12 -> HIT; row 0x34 -> CONFLICT, row_conflict=0x0012, open_count 1->0.
REQ-036 HIT with row_resolve=1 on index 5 -> row_stat=01, open_count drops by 1, next same request -> MISS.
REQ-037 TIMEOUT=4: MISS on index 3, idle 4 cycles -> close_valid=1, close_bank=3; hold close_ready=0 3 cycles -> outputs stable; close_ready=1 -> close_valid=0 next cycle, open_count=0.
REQ-038 TIMEOUT=4: indexes 2 and 9 expire same cycle -> close_bank=2 first, after handshake close_bank=9; request to index 2 while offered -> req_ready=0.
REQ-039 Open 4 banks, assert refresh with req_valid=1 -> req_ready=0, next cycle open_count=0, close_valid=0, all subsequent requests MISS.
REQ-040 Drop nRST mid-close handshake with close_valid=1 -> all outputs 0 immediately; after release, prior rows report MISS.
